sc_run_ctrl: RTL and testbench

//  Run/halt/single-step sequencer for the single-cycle CPU. Produces cpu_ce, which qualifies every

---
 rtl/sc_run_ctrl_pkg.sv | 10 +
 rtl/sc_run_ctrl_if.sv | 22 ++
 rtl/sc_run_ctrl_debounce.sv | 39 +++
 rtl/sc_run_ctrl.sv | 63 ++++++
 tb/tb_sc_run_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_run_ctrl_pkg.sv
// sc_run_ctrl_pkg: run-state encodings shared by the run controller and the status hub
package sc_run_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_e;
  localparam int DEBOUNCE_DEFAULT = 500000;
endpackage

// File: rtl/sc_run_ctrl_if.sv
// sc_run_ctrl_if: CPU/hub-facing bus of the run controller
interface sc_run_ctrl_if #(
  parameter int CNT_W = 32
);
  import sc_run_ctrl_pkg::*;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic             clr_count;
  logic             cpu_ce;
  run_state_e       run_state;
  logic             brk_hit;
  logic [CNT_W-1:0] cycle_count;
  modport master (
    input  bp_en, bp_addr, pc, clr_count,
    output cpu_ce, run_state, brk_hit, cycle_count
  );
  modport slave (
    output bp_en, bp_addr, pc, clr_count,
    input  cpu_ce, run_state, brk_hit, cycle_count
  );
endinterface

// File: rtl/sc_run_ctrl_debounce.sv
// sc_run_ctrl_debounce: key synchroniser and debouncer, one-cycle pulse on a settled press
module sc_run_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          settled;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end
  // the count runs only while the synced level disagrees with the accepted one
  always_comb begin
    settled = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d   = (sync2_q == level_q || settled) ? '0 : cnt_q + 1'b1;
    level_d = settled ? sync2_q : level_q;
    press_d = level_q & ~level_d;
  end
  assign press = press_q;
endmodule

// File: rtl/sc_run_ctrl.sv
// sc_run_ctrl: run/halt/single-step sequencer with PC breakpoint and executed-cycle counter
module sc_run_ctrl
  import sc_run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 32
) (
  input logic           clock,
  input logic           resetn,
  input logic           key_run_n,
  input logic           key_step_n,
  sc_run_ctrl_if.master bus
);
  logic             run_press, step_press;
  logic             bp_match, cpu_ce;
  run_state_e       state_q, state_d;
  logic             bp_mask_q, bp_mask_d;
  logic [CNT_W-1:0] count_q, count_d;
  sc_run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .clock (clock),
    .resetn(resetn),
    .key_n (key_run_n),
    .press (run_press)
  );
  sc_run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .clock (clock),
    .resetn(resetn),
    .key_n (key_step_n),
    .press (step_press)
  );
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_HALT;
      bp_mask_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bp_mask_q <= bp_mask_d;
      count_q   <= count_d;
    end
  end
  // leaving BREAK masks the breakpoint until the held instruction has committed
  always_comb begin
    case (state_q)
      ST_HALT: state_d = run_press ? ST_RUN : step_press ? ST_STEP : ST_HALT;
      ST_RUN:  state_d = run_press ? ST_HALT : bp_match ? ST_BREAK : ST_RUN;
      ST_STEP: state_d = ST_HALT;
      default: state_d = run_press ? ST_RUN : step_press ? ST_STEP : ST_BREAK;
    endcase
    bp_mask_d = (state_q == ST_BREAK && (run_press || step_press)) ? 1'b1 :
                cpu_ce ? 1'b0 : bp_mask_q;
    count_d   = bus.clr_count ? '0 :
                (cpu_ce && !(&count_q)) ? count_q + 1'b1 : count_q;
  end
  always_comb begin
    bp_match = bus.bp_en && (bus.pc == bus.bp_addr) && !bp_mask_q;
    cpu_ce   = (state_q == ST_RUN) ? !bp_match : (state_q == ST_STEP);
  end
  assign bus.cpu_ce      = cpu_ce;
  assign bus.run_state   = state_q;
  assign bus.brk_hit     = (state_q == ST_BREAK);
  assign bus.cycle_count = count_q;
endmodule

// File: tb/tb_sc_run_ctrl.sv
// tb_sc_run_ctrl: directed bench with a commit scoreboard and a 3-bit counter twin for saturation
module tb_sc_run_ctrl;
  import sc_run_ctrl_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    run_state_e  st;
  } rec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_run_n = 1'b1;
  logic        key_step_n = 1'b1;
  logic        pc_zero = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic        clr = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] p0;
  int          errors = 0, checks = 0, seen_ce = 0, rec_left = 0, gaps = 0, gaps2 = 0;
  bit          strict = 1'b1;
  rec_t        exp_q[$], got_q[$];

  sc_run_ctrl_if #(.CNT_W(32)) bus ();
  sc_run_ctrl_if #(.CNT_W(3))  sbus ();

  sc_run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(32)) dut (
    .clock     (clk),
    .resetn    (rst_n),
    .key_run_n (key_run_n),
    .key_step_n(key_step_n),
    .bus       (bus)
  );
  sc_run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut_sat (
    .clock     (clk),
    .resetn    (rst_n),
    .key_run_n (key_run_n),
    .key_step_n(key_step_n),
    .bus       (sbus)
  );

  assign bus.pc         = pc;
  assign bus.bp_en      = bp_en;
  assign bus.bp_addr    = bp_addr;
  assign bus.clr_count  = clr;
  assign sbus.pc        = pc;
  assign sbus.bp_en     = bp_en;
  assign sbus.bp_addr   = bp_addr;
  assign sbus.clr_count = clr;

  always #5 clk = ~clk;

  // CPU PC model: advances one instruction per enabled cycle
  always @(posedge clk) pc <= pc_zero ? 32'd0 : bus.cpu_ce ? pc + 32'd4 : pc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(logic [31:0] p, run_state_e s);
    rec_t r;
    r.pc = p;
    r.st = s;
    exp_q.push_back(r);
  endtask

  task automatic tick(int n = 1);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst_n && bus.cpu_ce) begin
        seen_ce++;
        if (strict || rec_left > 0) begin
          r.pc = bus.pc;
          r.st = bus.run_state;
          got_q.push_back(r);
          if (rec_left > 0) rec_left--;
        end
      end
    end
  endtask

  task automatic drain(string tag);
    check({tag, " commits"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic press_key(bit r, bit s, int n);
    key_run_n  = !r;
    key_step_n = !s;
    tick(n);
    key_run_n  = 1'b1;
    key_step_n = 1'b1;
  endtask

  task automatic wait_state(run_state_e s, int bound, string tag);
    for (int i = 0; i < bound && bus.run_state !== s; i++) tick();
    check(tag, bus.run_state, s);
  endtask

  task automatic halt_run(string tag, output int g);
    g = 0;
    key_run_n = 1'b0;
    for (int i = 0; i < 40 && bus.run_state !== ST_HALT; i++) begin
      tick();
      if (i == 8) key_run_n = 1'b1;
      if (bus.run_state === ST_RUN && !bus.cpu_ce) g++;
    end
    key_run_n = 1'b1;
    tick(12);
    check(tag, bus.run_state, ST_HALT);
  endtask

  initial begin
    tick(3);
    check("rst ce", bus.cpu_ce, 0);
    check("rst state", bus.run_state, ST_HALT);
    check("rst count", bus.cycle_count, 0);
    check("rst brk", bus.brk_hit, 0);
    rst_n = 1'b1;
    // idle keys: nothing may commit
    tick(100);
    drain("idle");
    check("idle state", bus.run_state, ST_HALT);
    check("idle count", bus.cycle_count, 0);
    // single step
    push(32'd0, ST_STEP);
    press_key(0, 1, 10);
    tick(20);
    drain("step");
    check("step state", bus.run_state, ST_HALT);
    check("step count", bus.cycle_count, 1);
    check("step pc", pc, 32'd4);
    // free run between two run presses
    strict = 1'b0;
    press_key(1, 0, 8);
    wait_state(ST_RUN, 20, "run enter");
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.run_state !== ST_RUN || !bus.cpu_ce) gaps++;
    end
    halt_run("run halt", gaps2);
    check("run gaps", gaps + gaps2, 0);
    check("run ce", bus.cpu_ce, 0);
    check("run long", seen_ce >= 21, 1);
    check("run count", bus.cycle_count, seen_ce);
    check("sat count", sbus.cycle_count, 7);
    // breakpoint at 0x10
    pc_zero = 1'b1;
    tick();
    pc_zero = 1'b0;
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    strict  = 1'b1;
    push(32'h0, ST_RUN);
    push(32'h4, ST_RUN);
    push(32'h8, ST_RUN);
    push(32'hC, ST_RUN);
    press_key(1, 0, 8);
    wait_state(ST_BREAK, 40, "bp enter");
    drain("bp run");
    check("bp ce", bus.cpu_ce, 0);
    check("bp brk", bus.brk_hit, 1);
    check("bp pc", pc, 32'h10);
    tick(10);
    check("bp hold", bus.run_state, ST_BREAK);
    drain("bp hold");
    strict   = 1'b0;
    rec_left = 2;
    push(32'h10, ST_RUN);
    push(32'h14, ST_RUN);
    press_key(1, 0, 8);
    tick(10);
    check("bp resume", bus.run_state, ST_RUN);
    drain("bp resume");
    halt_run("bp halt", gaps);
    check("bp gaps", gaps, 0);
    // a step landing on the breakpoint address halts rather than breaks
    p0      = pc;
    bp_addr = pc;
    strict  = 1'b1;
    push(p0, ST_STEP);
    press_key(0, 1, 8);
    tick(12);
    drain("step bp");
    check("step bp state", bus.run_state, ST_HALT);
    check("step bp brk", bus.brk_hit, 0);
    check("step bp pc", pc, p0 + 32'd4);
    bp_en = 1'b0;
    // short glitches must not register
    for (int r = 0; r < 2; r++)
      for (int g = 1; g <= 3; g++) begin
        key_run_n = 1'b0;
        tick(g);
        key_run_n = 1'b1;
        tick(2);
      end
    tick(10);
    drain("glitch");
    check("glitch state", bus.run_state, ST_HALT);
    strict = 1'b0;
    press_key(1, 1, 8);
    wait_state(ST_RUN, 20, "both keys");
    tick(15);
    check("both keys hold", bus.run_state, ST_RUN);
    // asynchronous reset mid-run
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst ce", bus.cpu_ce, 0);
    check("arst state", bus.run_state, ST_HALT);
    check("arst count", bus.cycle_count, 0);
    check("arst sat", sbus.cycle_count, 0);
    seen_ce = 0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("post rst state", bus.run_state, ST_HALT);
    // clear beats increment on an enabled cycle, then saturation
    press_key(1, 0, 8);
    wait_state(ST_RUN, 20, "clr run");
    tick(5);
    clr     = 1'b1;
    seen_ce = 0;
    tick();
    check("clr count", bus.cycle_count, 0);
    check("clr ce", bus.cpu_ce, 1);
    clr = 1'b0;
    tick(12);
    halt_run("clr halt", gaps);
    check("clr main", bus.cycle_count, seen_ce);
    check("clr sat", sbus.cycle_count, (seen_ce > 7) ? 7 : seen_ce);
    check("clr sat long", seen_ce > 7, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
